cpu_imm_gen_unit: RTL and testbench

Pipelined immediate generator that replaces the combinational sign-extend stage in the decode path. It accepts a full 32-bit RV32 instruction word and derives the immediate format from the opcode and funct3 itself. It sign- or zero-extends the immediate to DATA_WIDTH and delivers it one cycle later through a valid/ready output backed by a 2-entry skid buffer. It sits between fetch/decode and execute, and carries a sideband tag (typically the PC) alongside each result.

---
 rtl/cpu_imm_gen_unit.sv | 153 +++++++++++++++
 tb/tb_cpu_imm_gen_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_imm_gen_unit.sv
// Pipelined RV32 immediate generator: decodes the immediate format from the
// instruction word, extends it to DATA_WIDTH and returns it one cycle later
// through a valid/ready output register backed by a single skid register.
module cpu_imm_gen_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [2:0]            out_fmt,
  output logic                  out_illegal,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam logic [2:0] FMT_I     = 3'd0;
  localparam logic [2:0] FMT_S     = 3'd1;
  localparam logic [2:0] FMT_B     = 3'd2;
  localparam logic [2:0] FMT_J     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_SHAMT = 3'd5;
  localparam logic [2:0] FMT_ZIMM  = 3'd6;
  localparam logic [2:0] FMT_NONE  = 3'd7;

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [2:0]            w_fmt;
  logic                  w_illegal;
  logic [DATA_WIDTH-1:0] w_imm;
  logic                  w_accept;
  logic                  w_out_free;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_imm;
  logic [2:0]            r_out_fmt;
  logic                  r_out_illegal;
  logic [TAG_WIDTH-1:0]  r_out_tag;

  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_imm;
  logic [2:0]            r_skid_fmt;
  logic                  r_skid_illegal;
  logic [TAG_WIDTH-1:0]  r_skid_tag;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];

  // Format decode from opcode and funct3
  always_comb begin
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    case (w_opcode)
      7'b0000011, 7'b1100111, 7'b0001111: w_fmt = FMT_I;
      7'b0010011: w_fmt = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
      7'b0100011: w_fmt = FMT_S;
      7'b1100011: w_fmt = FMT_B;
      7'b1101111: w_fmt = FMT_J;
      7'b0110111, 7'b0010111: w_fmt = FMT_U;
      7'b1110011: w_fmt = w_funct3[2] ? FMT_ZIMM : FMT_I;
      default: begin
        w_fmt     = FMT_NONE;
        w_illegal = 1'b1;
      end
    endcase
  end

  // Immediate extraction and extension for the decoded format
  always_comb begin
    w_imm = '0;
    case (w_fmt)
      FMT_I: w_imm = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
      FMT_S: w_imm = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: w_imm = {{(DATA_WIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_J: w_imm = {{(DATA_WIDTH-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      FMT_U: w_imm = {{(DATA_WIDTH-32){in_instr[31]}}, in_instr[31:12], 12'b0};
      FMT_SHAMT: w_imm = (DATA_WIDTH == 64) ? DATA_WIDTH'(in_instr[25:20])
                                            : DATA_WIDTH'(in_instr[24:20]);
      FMT_ZIMM: w_imm = DATA_WIDTH'(in_instr[19:15]);
      default:  w_imm = '0;
    endcase
  end

  // Skid register empty means a new instruction can always be absorbed
  assign in_ready   = ~r_skid_valid;
  assign w_accept   = in_valid & in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

  // Output register: refilled from skid first (FIFO order), else from input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_imm     <= '0;
      r_out_fmt     <= FMT_NONE;
      r_out_illegal <= 1'b0;
      r_out_tag     <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid   <= 1'b1;
        r_out_imm     <= r_skid_imm;
        r_out_fmt     <= r_skid_fmt;
        r_out_illegal <= r_skid_illegal;
        r_out_tag     <= r_skid_tag;
      end else if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_imm     <= w_imm;
        r_out_fmt     <= w_fmt;
        r_out_illegal <= w_illegal;
        r_out_tag     <= in_tag;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Skid register: captures an accept while the output register is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid   <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_fmt     <= FMT_NONE;
      r_skid_illegal <= 1'b0;
      r_skid_tag     <= '0;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      r_skid_valid   <= 1'b1;
      r_skid_imm     <= w_imm;
      r_skid_fmt     <= w_fmt;
      r_skid_illegal <= w_illegal;
      r_skid_tag     <= in_tag;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_imm     = r_out_imm;
  assign out_fmt     = r_out_fmt;
  assign out_illegal = r_out_illegal;
  assign out_tag     = r_out_tag;

endmodule

// File: tb/tb_cpu_imm_gen_unit.sv
// Directed bench for cpu_imm_gen_unit: format/extension vectors at both data
// widths, backpressure ordering, flush and asynchronous reset.
module tb_cpu_imm_gen_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [31:0] out_tag;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic        out_illegal64;
  logic [7:0]  out_tag64;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] got_q[$];
  int          got_cyc[$];

  always #5 clk = ~clk;

  cpu_imm_gen_unit #(.DATA_WIDTH(32), .TAG_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  cpu_imm_gen_unit #(.DATA_WIDTH(64), .TAG_WIDTH(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag[7:0]),
    .out_valid(out_valid64), .out_ready(1'b1), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  // Delivery monitor for the 32-bit instance
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back(out_tag);
      got_cyc.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  localparam logic [31:0] TA = 32'h0000_1000;
  localparam logic [31:0] TB = 32'h0000_1004;
  localparam logic [31:0] TC = 32'h0000_1008;
  localparam logic [31:0] TD = 32'h0000_100C;

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd0, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0};
    vecs[2]  = '{32'h0010006F, 32'h00000800, 64'h00000000_00000800, 3'd3, 1'b0};
    vecs[3]  = '{32'hFE112C23, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd1, 1'b0};
    vecs[4]  = '{32'h123452B7, 32'h12345000, 64'h00000000_12345000, 3'd4, 1'b0};
    vecs[5]  = '{32'h800002B7, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
    vecs[6]  = '{32'h41F0D093, 32'h0000001F, 64'h00000000_0000001F, 3'd5, 1'b0};
    vecs[7]  = '{32'h0200D093, 32'h00000000, 64'h00000000_00000020, 3'd5, 1'b0};
    vecs[8]  = '{32'h300FD073, 32'h0000001F, 64'h00000000_0000001F, 3'd6, 1'b0};
    vecs[9]  = '{32'h0000007F, 32'h00000000, 64'h00000000_00000000, 3'd7, 1'b1};
    vecs[10] = '{32'hFFF02073, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd0, 1'b0};
    vecs[11] = '{32'h0FF0000F, 32'h000000FF, 64'h00000000_000000FF, 3'd0, 1'b0};
    vecs[12] = '{32'h80002003, 32'hFFFFF800, 64'hFFFFFFFF_FFFFF800, 3'd0, 1'b0};
    vecs[13] = '{32'h7FF00067, 32'h000007FF, 64'h00000000_000007FF, 3'd0, 1'b0};
    vecs[14] = '{32'hFFFFF097, 32'hFFFFF000, 64'hFFFFFFFF_FFFFF000, 3'd4, 1'b0};
    vecs[15] = '{32'h00509093, 32'h00000005, 64'h00000000_00000005, 3'd5, 1'b0};
    vecs[16] = '{32'h00000033, 32'h00000000, 64'h00000000_00000000, 3'd7, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_imm", 64'(out_imm), 64'd0);
    check("rst out_fmt", 64'(out_fmt), 64'd7);
    check("rst out_illegal", 64'(out_illegal), 64'd0);
    check("rst out_tag", 64'(out_tag), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);

    // Back-to-back vectors with the consumer always ready
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_tag   = 32'hA000_0000 + 32'(i);
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d out_imm", i), 64'(out_imm), 64'(vecs[i].imm32));
      check($sformatf("v%0d out_fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
      check($sformatf("v%0d out_illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
      check($sformatf("v%0d out_tag", i), 64'(out_tag), 64'(32'hA000_0000 + 32'(i)));
      check($sformatf("v%0d imm64", i), out_imm64, vecs[i].imm64);
      check($sformatf("v%0d fmt64", i), 64'(out_fmt64), 64'(vecs[i].fmt));
      check($sformatf("v%0d tag64", i), 64'(out_tag64), 64'(8'(i)));
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain out_valid", 64'(out_valid), 64'd0);

    // Backpressure: A and B accepted, C held off, then A,B,C in order
    @(negedge clk);
    out_ready = 1'b0;
    got_q.delete(); got_cyc.delete();
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = TA;
    @(posedge clk); #1;
    check("bp A visible", 64'(out_tag), 64'(TA));
    check("bp in_ready after A", 64'(in_ready), 64'd1);
    @(negedge clk) begin in_instr = 32'h123452B7; in_tag = TB; end
    @(posedge clk); #1;
    check("bp in_ready after B", 64'(in_ready), 64'd0);
    check("bp A held", 64'(out_tag), 64'(TA));
    @(negedge clk) begin in_instr = 32'h0010006F; in_tag = TC; end
    repeat (2) @(posedge clk);
    #1;
    check("bp stall out_valid", 64'(out_valid), 64'd1);
    check("bp stall tag", 64'(out_tag), 64'(TA));
    check("bp stall imm", 64'(out_imm), 64'hFFFFFFFF);
    check("bp stall in_ready", 64'(in_ready), 64'd0);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp B out", 64'(out_tag), 64'(TB));
    check("bp B imm", 64'(out_imm), 64'h12345000);
    check("bp in_ready reopen", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp C out", 64'(out_tag), 64'(TC));
    check("bp C imm", 64'(out_imm), 64'h00000800);
    @(posedge clk); #1;
    check("bp drained", 64'(out_valid), 64'd0);
    check("bp delivered count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check("bp order 0", 64'(got_q[0]), 64'(TA));
      check("bp order 1", 64'(got_q[1]), 64'(TB));
      check("bp order 2", 64'(got_q[2]), 64'(TC));
      check("bp no gap 1", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
      check("bp no gap 2", 64'(got_cyc[2] - got_cyc[1]), 64'd1);
    end

    // Flush at occupancy 2 with a third instruction offered
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = TA;
    @(negedge clk) begin in_instr = 32'h123452B7; in_tag = TB; end
    @(negedge clk) begin in_instr = 32'h0010006F; in_tag = TC; flush = 1'b1; end
    got_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("fl2 out_valid", 64'(out_valid), 64'd0);
    check("fl2 in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("fl2 nothing delivered", 64'(got_q.size()), 64'd0);

    // Flush at occupancy 1 while an instruction is being accepted
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = TA;
    @(negedge clk) begin in_instr = 32'h123452B7; in_tag = TB; flush = 1'b1; end
    got_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("fl1 out_valid", 64'(out_valid), 64'd0);
    check("fl1 in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("fl1 nothing delivered", 64'(got_q.size()), 64'd0);
    @(negedge clk) begin in_valid = 1'b1; in_instr = 32'h300FD073; in_tag = TD; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("fl1 recover tag", 64'(out_tag), 64'(TD));
    check("fl1 recover fmt", 64'(out_fmt), 64'd6);

    // Asynchronous reset at occupancy 2
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = TA;
    @(negedge clk) begin in_instr = 32'h123452B7; in_tag = TB; end
    @(negedge clk) in_valid = 1'b0;
    check("ar pre occupancy", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar out_valid async", 64'(out_valid), 64'd0);
    check("ar out_fmt async", 64'(out_fmt), 64'd7);
    check("ar out_tag async", 64'(out_tag), 64'd0);
    got_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ar in_ready after", 64'(in_ready), 64'd1);
    check("ar out_valid after", 64'(out_valid), 64'd0);
    @(negedge clk) out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ar nothing delivered", 64'(got_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
